// File: rtl/spmem32_arbiter_if.sv
// Request/response and scratchpad bus bundle for spmem32_arbiter.
// The slave modport is the arbiter side. The master modport is the requesters plus the memory.
interface spmem32_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 10
);
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ-1:0]          req_lock;
  logic [NREQ-1:0]          req_wr;
  logic [NREQ-1:0][AW-1:0]  req_addr;
  logic [NREQ-1:0][31:0]    req_wdata;
  logic [NREQ-1:0]          resp_valid;
  logic [31:0]              resp_rdata;
  logic                     mem_en;
  logic                     mem_wr;
  logic [AW-1:0]            mem_addr;
  logic [31:0]              mem_wdata;
  logic [31:0]              mem_rdata;

  modport master (
    output req_valid, req_lock, req_wr, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_lock, req_wr, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/spmem32_arbiter.sv
// Round-robin arbiter with lock, sharing one spMem32 among NREQ requesters. Fixed 3-cycle response latency.
// Optional SPMEM_ARB_STATS_EN adds the stat_conflicts saturating counter.
module spmem32_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 10
) (
  input  logic                clk,
  input  logic                reset,
  spmem32_arbiter_if.slave    bus
`ifdef SPMEM_ARB_STATS_EN
  ,
  output logic [31:0]         stat_conflicts
`endif
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ARB, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, owner_q, owner_d, gnt_id, ptr_nxt;
  logic [NREQ-1:0]    gnt;
  logic               hs, found, conflict;

  logic [1:0]         vld_pipe, wr_pipe;
  logic [1:0][PW-1:0] id_pipe;
  logic [AW-1:0]      mem_addr_q;
  logic [31:0]        mem_wdata_q, resp_rdata_q;
  logic [NREQ-1:0]    resp_valid_q;

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Grant: only the owner while locked. Otherwise the first valid requester at or after the pointer.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    if (state_q == LOCKED) begin
      if (bus.req_valid[owner_q]) begin
        gnt[owner_q] = 1'b1;
        gnt_id       = owner_q;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && bus.req_valid[rr_idx(ptr_q, k)]) begin
          found              = 1'b1;
          gnt[rr_idx(ptr_q, k)] = 1'b1;
          gnt_id             = rr_idx(ptr_q, k);
        end
      end
    end
    if (!reset) gnt = '0;
  end

  assign hs            = |gnt;
  assign bus.req_ready = gnt;
  assign ptr_nxt       = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
  assign conflict      = |(bus.req_valid & ~gnt);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ARB: begin
        if (hs && bus.req_lock[gnt_id]) begin
          state_d = LOCKED;
          owner_d = gnt_id;
        end
      end
      LOCKED: begin
        if (hs && !bus.req_lock[owner_q]) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (hs) ptr_q <= ptr_nxt;
    end
  end

  // Stage 0 drives the memory. Stage 1 waits on the read. The response register follows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe     <= '0;
      wr_pipe      <= '0;
      id_pipe      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], hs};
      wr_pipe  <= {wr_pipe[0], bus.req_wr[gnt_id]};
      id_pipe  <= {id_pipe[0], gnt_id};
      if (hs) begin
        mem_addr_q  <= bus.req_addr[gnt_id];
        mem_wdata_q <= bus.req_wdata[gnt_id];
      end
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      if (vld_pipe[1]) begin
        resp_valid_q[id_pipe[1]] <= 1'b1;
        resp_rdata_q             <= wr_pipe[1] ? 32'd0 : bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en     = vld_pipe[0];
  assign bus.mem_wr     = vld_pipe[0] & wr_pipe[0];
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;

`ifdef SPMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stat_conflicts <= '0;
    else if (conflict && stat_conflicts != 32'hFFFF_FFFF) stat_conflicts <= stat_conflicts + 32'd1;
  end
`else
  logic unused_conflict;
  assign unused_conflict = conflict;
`endif
endmodule

// File: tb/tb_spmem32_arbiter.sv
// Scoreboard bench for spmem32_arbiter: stimulus pushes expected memory and response events.
// A negedge monitor pops and compares them.
module tb_spmem32_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 10;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  spmem32_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus ();

`ifdef SPMEM_ARB_STATS_EN
  logic [31:0] stat_conflicts;
  logic [31:0] snap;
`endif

  spmem32_arbiter #(.NREQ(NREQ), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef SPMEM_ARB_STATS_EN
    ,
    .stat_conflicts (stat_conflicts)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scratchpad model with synchronous read and 1-cycle latency.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_wr) mem[bus.mem_addr] = bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  typedef struct {
    int          cyc;
    int          id;
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t mq[$];
  exp_t rq[$];
  exp_t mm, rr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_acc(input int id, input logic w, input logic [9:0] a,
                            input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    e.id = id; e.wr = w; e.addr = a; e.wdata = wd; e.rdata = rd;
    e.cyc = cyc + 1; mq.push_back(e);
    e.cyc = cyc + 3; rq.push_back(e);
  endtask

  task automatic drv(input int i, input logic v, input logic lk, input logic w,
                     input logic [9:0] a, input logic [31:0] d);
    bus.req_valid[i] = v;
    bus.req_lock[i]  = lk;
    bus.req_wr[i]    = w;
    bus.req_addr[i]  = a;
    bus.req_wdata[i] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rdy(input string name, input logic [3:0] exp);
    #1;
    chk(name, {28'd0, bus.req_ready}, {28'd0, exp});
  endtask

  task automatic all_idle();
    for (int i = 0; i < NREQ; i++) drv(i, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic chk_zero_outputs();
    chk("rst_req_ready",  {28'd0, bus.req_ready}, 32'd0);
    chk("rst_resp_valid", {28'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_mem_en",     {31'd0, bus.mem_en}, 32'd0);
    chk("rst_mem_wr",     {31'd0, bus.mem_wr}, 32'd0);
    chk("rst_mem_addr",   {22'd0, bus.mem_addr}, 32'd0);
    chk("rst_mem_wdata",  bus.mem_wdata, 32'd0);
`ifdef SPMEM_ARB_STATS_EN
    chk("rst_stats", stat_conflicts, 32'd0);
`endif
  endtask

  // Monitor: every mem_en and every response must match the head of its queue.
  always @(negedge clk) begin
    if (bus.mem_en === 1'b1) begin
      if (mq.size() == 0) chk("mem_unexpected", 32'd1, 32'd0);
      else begin
        mm = mq.pop_front();
        chk("mem_cyc",  cyc, mm.cyc);
        chk("mem_wr",   {31'd0, bus.mem_wr}, {31'd0, mm.wr});
        chk("mem_addr", {22'd0, bus.mem_addr}, {22'd0, mm.addr});
        if (mm.wr) chk("mem_wdata", bus.mem_wdata, mm.wdata);
      end
    end
    if (bus.resp_valid !== '0) begin
      if (rq.size() == 0) chk("resp_unexpected", {28'd0, bus.resp_valid}, 32'd0);
      else begin
        rr = rq.pop_front();
        chk("resp_cyc",   cyc, rr.cyc);
        chk("resp_id",    {28'd0, bus.resp_valid}, 32'd1 << rr.id);
        chk("resp_rdata", bus.resp_rdata, rr.rdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
    mem[10'h005] = 32'hDEADBEEF;
    for (int i = 0; i < NREQ; i++) mem[10'h010 + i] = 32'hA0 + i;

    reset = 1'b0;
    all_idle();
    #1;
    chk_zero_outputs();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Round-robin: all requesters hold valid for 8 cycles.
    for (int i = 0; i < NREQ; i++) drv(i, 1'b1, 1'b0, 1'b0, 10'h010 + 10'(i), '0);
    for (int k = 0; k < 8; k++) begin
      chk_rdy("rr_ready", 4'b0001 << (k % 4));
      expect_acc(k % 4, 1'b0, 10'h010 + 10'(k % 4), '0, 32'hA0 + (k % 4));
      tick();
    end
    all_idle();
    repeat (4) tick();

    // Single read from requester 0.
    drv(0, 1'b1, 1'b0, 1'b0, 10'h005, '0);
    chk_rdy("single_ready", 4'b0001);
    expect_acc(0, 1'b0, 10'h005, '0, 32'hDEADBEEF);
    tick();
    all_idle();
    repeat (4) tick();

    // Lock: requester 2 reads locked, idles 2 cycles, then a final write while others wait.
    drv(2, 1'b1, 1'b1, 1'b0, 10'h012, '0);
    chk_rdy("lock_first", 4'b0100);
    expect_acc(2, 1'b0, 10'h012, '0, 32'hA2);
    tick();
    drv(2, 1'b0, 1'b0, 1'b0, '0, '0);
    drv(0, 1'b1, 1'b0, 1'b0, 10'h010, '0);
    drv(1, 1'b1, 1'b0, 1'b0, 10'h011, '0);
    drv(3, 1'b1, 1'b0, 1'b0, 10'h013, '0);
    chk_rdy("lock_idle1", 4'b0000);
    tick();
    chk_rdy("lock_idle2", 4'b0000);
    tick();
    drv(2, 1'b1, 1'b0, 1'b1, 10'h020, 32'h55AA55AA);
    chk_rdy("lock_last", 4'b0100);
    expect_acc(2, 1'b1, 10'h020, 32'h55AA55AA, 32'd0);
    tick();
    drv(2, 1'b0, 1'b0, 1'b0, '0, '0);
    chk_rdy("unlock_next3", 4'b1000);
    expect_acc(3, 1'b0, 10'h013, '0, 32'hA3);
    tick();
    drv(3, 1'b0, 1'b0, 1'b0, '0, '0);
    chk_rdy("unlock_next0", 4'b0001);
    expect_acc(0, 1'b0, 10'h010, '0, 32'hA0);
    tick();
    drv(0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk_rdy("unlock_next1", 4'b0010);
    expect_acc(1, 1'b0, 10'h011, '0, 32'hA1);
    tick();
    all_idle();
    repeat (4) tick();

    // Read back the locked write.
    drv(0, 1'b1, 1'b0, 1'b0, 10'h020, '0);
    chk_rdy("rb_ready", 4'b0001);
    expect_acc(0, 1'b0, 10'h020, '0, 32'h55AA55AA);
    tick();
    all_idle();
    repeat (4) tick();

    // Write then read the top address on back-to-back cycles.
    drv(1, 1'b1, 1'b0, 1'b1, 10'h3FF, 32'h12345678);
    chk_rdy("wr_ready", 4'b0010);
    expect_acc(1, 1'b1, 10'h3FF, 32'h12345678, 32'd0);
    tick();
    drv(1, 1'b0, 1'b0, 1'b0, '0, '0);
    drv(3, 1'b1, 1'b0, 1'b0, 10'h3FF, '0);
    chk_rdy("raw_ready", 4'b1000);
    expect_acc(3, 1'b0, 10'h3FF, '0, 32'h12345678);
    tick();
    all_idle();
    repeat (4) tick();

    // Async reset while an access is in flight: it must vanish.
    drv(1, 1'b1, 1'b0, 1'b0, 10'h005, '0);
    chk_rdy("pre_rst_ready", 4'b0010);
    tick();
    all_idle();
    mq.delete();
    rq.delete();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) drv(i, 1'b1, 1'b0, 1'b0, 10'h010 + 10'(i), '0);
    #1;
    chk_zero_outputs();
    tick();
    tick();
    all_idle();
    reset = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < NREQ; i++) drv(i, 1'b1, 1'b0, 1'b0, 10'h010 + 10'(i), '0);
    chk_rdy("post_rst_ptr", 4'b0001);
    expect_acc(0, 1'b0, 10'h010, '0, 32'hA0);
    tick();
    all_idle();
    repeat (4) tick();

    // Three requesters contend for 4 cycles. The pointer is 1 here.
    for (int i = 0; i < 3; i++) drv(i, 1'b1, 1'b0, 1'b0, 10'h010 + 10'(i), '0);
`ifdef SPMEM_ARB_STATS_EN
    snap = stat_conflicts;
`endif
    for (int k = 0; k < 4; k++) begin
      int g;
      g = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 0 : 1;
      chk_rdy("contend_ready", 4'b0001 << g);
      expect_acc(g, 1'b0, 10'h010 + 10'(g), '0, 32'hA0 + g);
      tick();
    end
`ifdef SPMEM_ARB_STATS_EN
    chk("stat_conflicts", stat_conflicts - snap, 32'd4);
`endif
    all_idle();

    repeat (8) tick();
    chk("mem_queue_drained",  mq.size(), 32'd0);
    chk("resp_queue_drained", rq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spmem32_arbiter.md
Name: spmem32_arbiter

Overview:
Shares one single-port 32-bit scratchpad memory (spMem32, synchronous read, 1-cycle latency) among NREQ requesters. Uses round-robin arbitration with per-requester valid/ready request handshakes and a lock mechanism for atomic multi-access sequences (read-modify-write). Every accepted request gets exactly one response, routed back to its requester. Sits between engine datapaths and the spMem32 instance.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 10, scratchpad word-address width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  NREQ  request valid per requester
req_ready  out  NREQ  request accepted; at most one bit high
req_lock  in  NREQ  keep grant after this access
req_wr  in  NREQ  1=write, 0=read
req_addr  in  NREQ*AW  word address; slice i = requester i
req_wdata  in  NREQ*32  write data; slice i = requester i
resp_valid  out  NREQ  one-cycle response pulse per requester
resp_rdata  out  32  read data (shared); 0 for write responses
mem_en  out  1  memory access strobe
mem_wr  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid cycle after mem_en

Behaviour:
- Reset (reset=0, async): state=ARB, rr pointer=0, all pipeline valids=0. req_ready, resp_valid, mem_en, mem_wr=0; mem_addr, mem_wdata, resp_rdata=0.
- req_ready is combinational from state, pointer and req_valid. Handshake occurs when req_valid[i]&req_ready[i]. Throughput: one access per cycle.
- ARB state: grant the first valid requester scanning pointer, pointer+1, ... mod NREQ. On handshake by i: pointer <= (i+1) mod NREQ. If req_lock[i]=1, go to LOCKED, owner=i.
- LOCKED state: only owner may get req_ready; all others held 0, even if owner is idle. Owner handshake with req_lock=0 is its last locked access: go to ARB, pointer <= owner+1. Owner handshake with req_lock=1 stays LOCKED. No timeout.
- Pipeline: handshake in cycle T; mem_en/mem_wr/mem_addr/mem_wdata registered and valid in T+1; mem_rdata sampled in T+2; resp_valid[i] and resp_rdata registered and valid in T+3. Latency is fixed at 3 cycles for reads and writes.
- Requester id and wr flag travel with each pipeline stage. Write responses return resp_rdata=0.
- Responses have no backpressure; requesters must accept resp_valid.
- When there is no handshake, mem_en=0 next cycle. mem_addr/mem_wdata hold their last value.
- Back-to-back read-after-write to the same address by any requesters returns the new data (memory ordering, no reordering in arbiter).
- NREQ=1: always grant, pointer stays 0.
- Reset mid-operation: in-flight accesses are dropped, and no resp_valid is produced for them.

Optional Feature:
SPMEM_ARB_STATS_EN. When defined, adds output stat_conflicts (32 bits). It increments once per cycle in which req_valid has ≥1 bit set that is not granted (ARB or LOCKED). It saturates at 0xFFFFFFFF and resets to 0. When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Single read: preload mem[0x05]=0xDEADBEEF; req0 reads 0x05 at T -> mem_en=1, mem_addr=0x05 at T+1; resp_valid=0001, resp_rdata=0xDEADBEEF at T+3.
- Round-robin: all 4 requesters hold req_valid for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3, one per cycle.
- Lock: req2 read with lock=1, then idles 2 cycles, then write with lock=0, while req0/1/3 request -> no other grants until req2's write; next grant goes to req3.
- Write then read: req1 writes 0x12345678 to 0x3FF, req3 reads 0x3FF the next cycle -> req1 resp_rdata=0, req3 resp_rdata=0x12345678, one cycle apart.
- Async reset: assert reset=0 between mem_en and resp_valid -> all outputs 0 immediately; no resp_valid after release; pointer restarts at 0.
- STATS (SPMEM_ARB_STATS_EN): 3 requesters contend for 4 cycles -> stat_conflicts=4.
